sbox_seq_ctrl: RTL and testbench

SBOX_SEQ_CTRL -- requirements
Module: sbox_seq_ctrl

---
 rtl/sbox_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_sbox_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_seq_ctrl.sv
// sbox_seq_ctrl
//   Sequences the eight DES S-box lookups of one 48-bit expanded, key-mixed
//   word through a single shared S-box bank, one lookup per clock, and
//   assembles the eight 4-bit results into a 32-bit word.
//
//   Configuration macro: SBOX_SEQ_PPERM_EN
//     undefined -> out_data is the raw concatenation S1..S8 (S1 in [31:28])
//     defined   -> out_data is the DES P-permutation of that concatenation,
//                  applied combinationally (no extra latency)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers in_data
//   in_ready   block can accept a word (IDLE only)
//   in_data    48-bit S-box input word, [47:42] -> S1 ... [5:0] -> S8
//   flush      synchronous abort, returns to IDLE and drops any result
//   sb_sel     shared bank select (0 = S1 ... 7 = S8), 0 outside LOOKUP
//   sb_addr    6-bit raw S-box address, 0 outside LOOKUP
//   sb_dout    combinational bank result for the current sb_sel/sb_addr
//   out_valid  out_data holds a completed result (DONE only)
//   out_ready  consumer accepts out_data
//   out_data   32-bit assembled result
//   busy       high whenever the FSM is not in IDLE
module sbox_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  input  logic        flush,
  output logic [2:0]  sb_sel,
  output logic [5:0]  sb_addr,
  input  logic [3:0]  sb_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [47:0] in_reg;
  // Nibbles are collected here and only copied to out_reg on the final
  // lookup, so out_data never shows a partially built result.
  logic [27:0] acc_reg;
  logic [31:0] out_reg;

`ifdef SBOX_SEQ_PPERM_EN
  // DES P table: output bit i (1 = MSB) takes input bit P_TAB[i-1].
  localparam int P_TAB [32] = '{16,  7, 20, 21, 29, 12, 28, 17,
                                 1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9,
                                19, 13, 30,  6, 22, 11,  4, 25};

  function automatic logic [31:0] pperm(input logic [31:0] r);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      p[31-i] = r[32-P_TAB[i]];
    end
    return p;
  endfunction
`endif

  // 6-bit field of the held word for lookup number i (S1 field first).
  function automatic logic [5:0] field_sel(input logic [47:0] w,
                                           input logic [2:0]  i);
    logic [5:0] f;
    case (i)
      3'd0:    f = w[47:42];
      3'd1:    f = w[41:36];
      3'd2:    f = w[35:30];
      3'd3:    f = w[29:24];
      3'd4:    f = w[23:18];
      3'd5:    f = w[17:12];
      3'd6:    f = w[11:6];
      default: f = w[5:0];
    endcase
    return f;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = LOOKUP;
      LOOKUP:  if (idx == 3'd7)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Word capture, lookup index and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      in_reg  <= '0;
      acc_reg <= '0;
      out_reg <= '0;
    end else if (flush) begin
      idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg <= in_data;
            idx    <= '0;
          end
        end
        LOOKUP: begin
          acc_reg <= {acc_reg[23:0], sb_dout};
          idx     <= idx + 3'd1;
          if (idx == 3'd7) out_reg <= {acc_reg, sb_dout};
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sb_sel    = '0;
    sb_addr   = '0;
    if (state == LOOKUP) begin
      sb_sel  = idx;
      sb_addr = field_sel(in_reg, idx);
    end
`ifdef SBOX_SEQ_PPERM_EN
    out_data = pperm(out_reg);
`else
    out_data = out_reg;
`endif
  end

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
module tb_sbox_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        flush;
  logic [2:0]  sb_sel;
  logic [5:0]  sb_addr;
  logic [3:0]  sb_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // DES S-boxes S1..S8, each 4 rows x 16 columns, row-major.
  int sbox_t [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  // Behavioural shared S-box bank: row = {a5,a0}, column = a4..a1.
  assign sb_dout = 4'(sbox_t[{sb_sel, sb_addr[5], sb_addr[0], sb_addr[4:1]}]);

  sbox_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .sb_sel    (sb_sel),
    .sb_addr   (sb_addr),
    .sb_dout   (sb_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] s_model(input logic [47:0] w);
    logic [31:0] r;
    logic [5:0]  a;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      a = w[47-6*i -: 6];
      r[31-4*i -: 4] = 4'(sbox_t[i*64 + int'({a[5], a[0], a[4:1]})]);
    end
    return r;
  endfunction

`ifdef SBOX_SEQ_PPERM_EN
  int ptab [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  function automatic logic [31:0] p_model(input logic [31:0] r);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[31-i] = r[32-ptab[i]];
    return o;
  endfunction
`endif

  function automatic logic [31:0] ref_model(input logic [47:0] w);
`ifdef SBOX_SEQ_PPERM_EN
    return p_model(s_model(w));
`else
    return s_model(w);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers w in IDLE, waits for DONE, checks latency and the result.
  // Returns in the first DONE cycle; out_ready is left to the caller.
  task automatic send_word(input logic [47:0] w, input bit check_steps);
    int lat;
    logic [31:0] exp;
    in_data  = w;
    in_valid = 1'b1;
    chk("accept_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(ref_model(w));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (check_steps && lat < 8) begin
        chk("step_sel",  64'(sb_sel),  64'(lat));
        chk("step_addr", 64'(sb_addr), 64'(6'(w >> (6*(7-lat)))));
        chk("step_ready", 64'(in_ready), 64'd0);
      end
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'd8);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
    chk("out_data", 64'(out_data), 64'(exp));
    chk("done_in_ready", 64'(in_ready), 64'd0);
  endtask

  logic [31:0] held;
  int          vld_seen;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_sb_sel",    64'(sb_sel),    64'd0);
    chk("rst_sb_addr",   64'(sb_addr),   64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Zero word, consumer always ready
    out_ready = 1'b1;
`ifdef SBOX_SEQ_PPERM_EN
    chk("zero_ref", 64'(ref_model(48'h0)), 64'(p_model(32'hEFA72C4D)));
`else
    chk("zero_ref", 64'(ref_model(48'h0)), 64'h0000_0000_EFA7_2C4D);
`endif
    send_word(48'h0, 1'b1);
    chk("zero_busy", 64'(busy), 64'd1);
    tick();
    chk("zero_idle_ready", 64'(in_ready),  64'd1);
    chk("zero_idle_valid", 64'(out_valid), 64'd0);

    // S6 addressing
    send_word(48'h0000_0003_F000, 1'b1);
`ifndef SBOX_SEQ_PPERM_EN
    chk("s6_nibble", 64'(out_data[11:8]), 64'd13);
`endif
    tick();

    // Backpressure in DONE
    out_ready = 1'b0;
    send_word(48'h1234_5678_9ABC, 1'b0);
    held = out_data;
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data",  64'(out_data),  64'(held));
      chk("bp_ready", 64'(in_ready),  64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 64'(in_ready),  64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_data_kept",     64'(out_data),  64'(held));

    // Flush at idx=4 together with a new offer
    out_ready = 1'b0;
    in_data  = 48'hFEDC_BA98_7654;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("fl_idx4_sel", 64'(sb_sel), 64'd4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 48'h0F0F_0F0F_0F0F;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_busy",     64'(busy),     64'd0);
    chk("fl_sb_sel",   64'(sb_sel),   64'd0);
    chk("fl_data_kept", 64'(out_data), 64'(held));
    vld_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) vld_seen++;
      tick();
    end
    chk("fl_no_valid", 64'(vld_seen), 64'd0);

    // Flush in IDLE blocks acceptance
    flush    = 1'b1;
    in_valid = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_idle_block", 64'(in_ready), 64'd1);

    // Flush in DONE drops the pending result
    send_word(48'h0F0F_0F0F_0F0F, 1'b1);
    held  = out_data;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_done_valid", 64'(out_valid), 64'd0);
    chk("fl_done_ready", 64'(in_ready),  64'd1);
    chk("fl_done_data",  64'(out_data),  64'(held));

    // Asynchronous reset pulse in DONE
    send_word(48'hA5A5_5A5A_C3C3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",    64'(out_valid), 64'd0);
    chk("ar_data",     64'(out_data),  64'd0);
    chk("ar_in_ready", 64'(in_ready),  64'd1);
    chk("ar_busy",     64'(busy),      64'd0);
    #1;
    rst_n = 1'b1;
    send_word(48'h8000_0000_0001, 1'b1);

    // Back-to-back random words
    out_ready = 1'b1;
    tick();
    for (int n = 0; n < 1000; n++) begin
      send_word({16'($urandom), $urandom}, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
